// File: rtl/pq_pkg.sv
// pq_pkg
//   Shared types for the shift-register priority queue and its sequencing
//   controller.
//   kv_t            : packed key/value pair; a smaller key means higher priority.
//   KV_EMPTY        : value of an unoccupied stage (maximum key, zero value).
//   pq_ctrl_state_t : controller FSM states.
//   pq_op_t         : operation tag used for the round-robin preference.
package pq_pkg;

  localparam int KEY_W = 16;
  localparam int VAL_W = 16;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // An empty stage carries the largest possible key so that it always sorts
  // behind every real entry.
  localparam kv_t KV_EMPTY = {{KEY_W{1'b1}}, {VAL_W{1'b0}}};

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } pq_ctrl_state_t;

  typedef enum logic {
    OP_ENQ,
    OP_DEQ
  } pq_op_t;

endpackage

// File: rtl/sr_pq_ctrl_arb.sv
// sr_pq_ctrl_arb
//   Two-way arbiter between enqueue and dequeue so that the array only ever
//   sees one operation per cycle.
//   Parameters: ARB_MODE  0 = round-robin using rr_pref, 1 = dequeue wins.
//   Ports:
//     enq_elig, deq_elig : requests that are currently allowed to proceed
//     rr_pref            : which operation wins the next conflict (mode 0)
//     enq_grant, deq_grant : one-hot (or zero) grants
module sr_pq_ctrl_arb
  import pq_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic   enq_elig,
  input  logic   deq_elig,
  input  pq_op_t rr_pref,
  output logic   enq_grant,
  output logic   deq_grant
);

  // Without a conflict the single eligible request simply wins. On a
  // conflict the mode decides: fixed dequeue priority, or the stored
  // round-robin preference.
  always_comb begin
    enq_grant = 1'b0;
    deq_grant = 1'b0;
    if (enq_elig && deq_elig) begin
      if (ARB_MODE == 1) begin
        deq_grant = 1'b1;
      end else if (rr_pref == OP_ENQ) begin
        enq_grant = 1'b1;
      end else begin
        deq_grant = 1'b1;
      end
    end else begin
      enq_grant = enq_elig;
      deq_grant = deq_elig;
    end
  end

endmodule

// File: rtl/sr_pq_ctrl.sv
// sr_pq_ctrl
//   Sequencing controller for a shift-register priority queue array that
//   supports enqueue and dequeue only.  Arbitrates the two request channels,
//   tracks occupancy, captures the array head into a registered output slot
//   and generates the array's synchronous clear after reset and on flush.
//
//   Parameters: DEPTH (array stages), ARB_MODE (0 round-robin, 1 deq first)
//   Optional build macro: SR_PQ_CTRL_STATS_EN adds the hwm and
//   enq_stall_cnt statistics outputs.
//
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     flush                    : discard queue contents
//     enq_valid/enq_ready/enq_kv : enqueue handshake and payload
//     deq_valid/deq_ready      : dequeue handshake
//     out_valid/out_ready/out_kv : registered dequeued entry to consumer
//     pq_rst/pq_enq/pq_deq/pq_kvi : control and data to the array
//     pq_head                  : array stage 1 (current minimum)
//     count/full/empty         : occupancy
//     hwm, enq_stall_cnt       : statistics (only with SR_PQ_CTRL_STATS_EN)
module sr_pq_ctrl
  import pq_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int ARB_MODE = 0,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  kv_t              enq_kv,
  input  logic             deq_valid,
  output logic             deq_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output kv_t              out_kv,
  output logic             pq_rst,
  output logic             pq_enq,
  output logic             pq_deq,
  output kv_t              pq_kvi,
  input  kv_t              pq_head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef SR_PQ_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] hwm,
  output logic [15:0]      enq_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  pq_ctrl_state_t   state;
  pq_ctrl_state_t   state_next;
  pq_op_t           rr_pref;
  logic             active;
  logic             enq_elig;
  logic             deq_elig;
  logic             enq_grant;
  logic             deq_grant;
  logic [CNT_W-1:0] count_next;

  // State register.  Reset parks the FSM in INIT so the array receives one
  // clock edge with pq_rst high before any traffic is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: INIT and FLUSH each last exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = RUN;
      RUN:     state_next = flush ? FLUSH : RUN;
      FLUSH:   state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Output logic: array clear outside RUN, and request eligibility.  A
  // dequeue is only eligible when the output slot is free or being emptied
  // in this same cycle.
  always_comb begin
    pq_rst   = (state != RUN);
    active   = (state == RUN) && !flush;
    enq_elig = active && enq_valid && !full;
    deq_elig = active && deq_valid && !empty && (!out_valid || out_ready);
  end

  sr_pq_ctrl_arb #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .enq_elig  (enq_elig),
    .deq_elig  (deq_elig),
    .rr_pref   (rr_pref),
    .enq_grant (enq_grant),
    .deq_grant (deq_grant)
  );

  assign enq_ready = enq_grant;
  assign deq_ready = deq_grant;
  assign pq_enq    = enq_valid && enq_ready;
  assign pq_deq    = deq_valid && deq_ready;
  assign pq_kvi    = enq_kv;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);

  // Occupancy follows the array: the grants already block overflow and
  // underflow, so no explicit saturation is needed.
  always_comb begin
    count_next = count;
    if (state == FLUSH) begin
      count_next = '0;
    end else if (pq_enq) begin
      count_next = count + ONE_C;
    end else if (pq_deq) begin
      count_next = count - ONE_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Round-robin preference only moves when a conflict was actually resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_pref <= OP_ENQ;
    end else if ((ARB_MODE == 0) && enq_elig && deq_elig) begin
      rr_pref <= (rr_pref == OP_ENQ) ? OP_DEQ : OP_ENQ;
    end
  end

  // Output slot.  The array head is captured on the same edge the array
  // shifts.  A new capture takes priority over the consumer emptying the
  // slot, which gives back-to-back throughput.  Flush does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_kv    <= KV_EMPTY;
    end else if (pq_deq) begin
      out_valid <= 1'b1;
      out_kv    <= pq_head;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SR_PQ_CTRL_STATS_EN
  // High-water mark tracks the occupancy being written this edge; the stall
  // counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm           <= '0;
      enq_stall_cnt <= '0;
    end else if (state == FLUSH) begin
      hwm           <= '0;
      enq_stall_cnt <= '0;
    end else begin
      if (count_next > hwm) begin
        hwm <= count_next;
      end
      if ((state == RUN) && enq_valid && !enq_ready && (enq_stall_cnt != 16'hFFFF)) begin
        enq_stall_cnt <= enq_stall_cnt + 16'd1;
      end
    end
  end
`endif

  // The array must never be asked to insert and shift on the same edge, and
  // occupancy must stay within the array size.
  a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(pq_enq && pq_deq));
  a_count_range : assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

endmodule

// File: tb/tb_sr_pq_ctrl.sv
// tb_sr_pq_ctrl
//   Directed bench for sr_pq_ctrl (DEPTH=4, ARB_MODE=0) with a behavioural
//   sorted-array model standing in for the shift-register queue and a
//   scoreboard of expected dequeued entries.
module tb_sr_pq_ctrl;
  import pq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  kv_t              enq_kv;
  logic             deq_valid;
  logic             deq_ready;
  logic             out_valid;
  logic             out_ready;
  kv_t              out_kv;
  logic             pq_rst;
  logic             pq_enq;
  logic             pq_deq;
  kv_t              pq_kvi;
  kv_t              pq_head = KV_EMPTY;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
`ifdef SR_PQ_CTRL_STATS_EN
  logic [CNT_W-1:0] hwm;
  logic [15:0]      enq_stall_cnt;
`endif

  int  checks = 0;
  int  passes = 0;
  kv_t exp_q[$];
  kv_t arr[$];

  logic [15:0] first_order [3] = '{16'd2, 16'd5, 16'd9};
  logic [15:0] arb_deq     [2] = '{16'd7, 16'd8};

  sr_pq_ctrl #(
    .DEPTH    (DEPTH),
    .ARB_MODE (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_kv    (enq_kv),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kv    (out_kv),
    .pq_rst    (pq_rst),
    .pq_enq    (pq_enq),
    .pq_deq    (pq_deq),
    .pq_kvi    (pq_kvi),
    .pq_head   (pq_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef SR_PQ_CTRL_STATS_EN
    ,
    .hwm           (hwm),
    .enq_stall_cnt (enq_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Payload generator: value field derived from the key so entries are
  // distinguishable beyond their key.
  function automatic kv_t mk(input logic [15:0] k);
    kv_t r;
    r.key = k;
    r.val = k ^ 16'hA5A5;
    return r;
  endfunction

  // Behavioural array: sorted by key, new entries go behind equal keys,
  // stage 1 presented on pq_head one edge after each update.
  always @(posedge clk) begin : array_model
    int pos;
    if (pq_rst) begin
      arr.delete();
    end else if (pq_enq) begin
      pos = arr.size();
      for (int i = arr.size() - 1; i >= 0; i--) begin
        if (arr[i].key > pq_kvi.key) pos = i;
      end
      arr.insert(pos, pq_kvi);
    end else if (pq_deq) begin
      arr.delete(0);
    end
    pq_head <= (arr.size() != 0) ? arr[0] : KV_EMPTY;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs just after the falling edge; combinational
  // outputs are stable by the time this returns.
  task automatic applyStimulus(input logic ev, input logic [15:0] ek, input logic dv,
                               input logic ordy, input logic fl);
    @(negedge clk);
    enq_valid = ev;
    enq_kv    = mk(ek);
    deq_valid = dv;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Scoreboard: whenever the consumer takes the output slot, the oldest
  // expected entry must be what is presented.
  initial begin : sb_monitor
    kv_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checkOutput("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("sb_out_kv", out_kv, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset with both requests raised: nothing may be granted.
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b1; enq_kv = mk(16'd1);
    deq_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_pq_rst", pq_rst, 1);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_kv", out_kv, KV_EMPTY);
    checkOutput("rst_enq_ready", enq_ready, 0);
    checkOutput("rst_deq_ready", deq_ready, 0);
    checkOutput("rst_empty", empty, 1);
    @(negedge clk);
    rst = 1'b0; enq_valid = 1'b0; deq_valid = 1'b0;
    #1;
    checkOutput("init_pq_rst", pq_rst, 1);

    // Enqueue 5,2,9 and dequeue them in key order.
    applyStimulus(1, 16'd5, 0, 1, 0);
    checkOutput("run_pq_rst", pq_rst, 0);
    checkOutput("enq5_ready", enq_ready, 1);
    applyStimulus(1, 16'd2, 0, 1, 0);
    applyStimulus(1, 16'd9, 0, 1, 0);
    applyStimulus(0, 16'd0, 0, 1, 0);
    checkOutput("count3", count, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 16'd0, 1, 1, 0);
      exp_q.push_back(mk(first_order[i]));
      checkOutput("deq_ready_seq", deq_ready, 1);
    end
    applyStimulus(0, 16'd0, 0, 1, 0);
    checkOutput("empty_after", empty, 1);
    checkOutput("count0_after", count, 0);
    applyStimulus(0, 16'd0, 1, 1, 0);
    checkOutput("deq_blocked_empty", deq_ready, 0);

    // Fill to DEPTH, then check the full boundary.
    applyStimulus(1, 16'd7, 0, 1, 0);
    applyStimulus(1, 16'd3, 0, 1, 0);
    applyStimulus(1, 16'd8, 0, 1, 0);
    applyStimulus(1, 16'd1, 0, 1, 0);
    applyStimulus(1, 16'd6, 0, 1, 0);
    checkOutput("full_flag", full, 1);
    checkOutput("full_enq_ready", enq_ready, 0);
    checkOutput("full_count", count, 4);
    applyStimulus(1, 16'd6, 1, 1, 0);
    exp_q.push_back(mk(16'd1));
    checkOutput("full_deq_wins", deq_ready, 1);
    checkOutput("full_enq_still_blocked", enq_ready, 0);
    applyStimulus(1, 16'd6, 0, 1, 0);
    checkOutput("enq_after_deq", enq_ready, 1);
    checkOutput("count_after_deq", count, 3);
    applyStimulus(0, 16'd0, 0, 1, 0);
    checkOutput("refill_count", count, 4);

    // Drain to half full: array holds {7,8} afterwards.
    applyStimulus(0, 16'd0, 1, 1, 0);
    exp_q.push_back(mk(16'd3));
    applyStimulus(0, 16'd0, 1, 1, 0);
    exp_q.push_back(mk(16'd6));

    // Both requests every cycle: grants alternate starting with enqueue.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'(20 + i), 1, 1, 0);
      checkOutput("arb_enq_grant", enq_ready, 32'(!i[0]));
      checkOutput("arb_deq_grant", deq_ready, 32'(i[0]));
      checkOutput("arb_exclusive", pq_enq & pq_deq, 0);
      if (i[0]) exp_q.push_back(mk(arb_deq[i / 2]));
    end
    applyStimulus(0, 16'd0, 0, 1, 0);
    checkOutput("arb_count", count, 2);

    // Output backpressure: second dequeue waits for the slot to be taken.
    applyStimulus(0, 16'd0, 1, 0, 0);
    checkOutput("bp_first_deq", deq_ready, 1);
    exp_q.push_back(mk(16'd20));
    applyStimulus(0, 16'd0, 1, 0, 0);
    checkOutput("bp_blocked", deq_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    applyStimulus(0, 16'd0, 1, 1, 0);
    checkOutput("bp_same_cycle_take", deq_ready, 1);
    exp_q.push_back(mk(16'd22));
    applyStimulus(0, 16'd0, 0, 0, 0);
    checkOutput("bp_reloaded_valid", out_valid, 1);
    checkOutput("bp_reloaded_kv", out_kv, mk(16'd22));
    checkOutput("bp_count", count, 0);

    // Flush with three entries queued and the slot occupied.
    applyStimulus(1, 16'd30, 0, 0, 0);
    applyStimulus(1, 16'd31, 0, 0, 0);
    applyStimulus(1, 16'd32, 0, 0, 0);
    applyStimulus(1, 16'd33, 1, 0, 1);
    checkOutput("flush_req_count", count, 3);
    checkOutput("flush_req_enq_ready", enq_ready, 0);
    applyStimulus(1, 16'd34, 1, 0, 0);
    checkOutput("flush_pq_rst", pq_rst, 1);
    checkOutput("flush_enq_ready", enq_ready, 0);
    checkOutput("flush_deq_ready", deq_ready, 0);
    applyStimulus(0, 16'd0, 1, 1, 0);
    checkOutput("post_flush_pq_rst", pq_rst, 0);
    checkOutput("post_flush_count", count, 0);
    checkOutput("post_flush_out_valid", out_valid, 1);
    checkOutput("post_flush_out_kv", out_kv, mk(16'd22));
    checkOutput("post_flush_deq_blocked", deq_ready, 0);

    // Reset in mid-stream with two entries queued and the slot occupied.
    applyStimulus(1, 16'd40, 0, 0, 0);
    applyStimulus(1, 16'd41, 0, 0, 0);
    applyStimulus(1, 16'd42, 0, 0, 0);
    applyStimulus(0, 16'd0, 1, 0, 0);
    applyStimulus(0, 16'd0, 0, 0, 0);
    checkOutput("pre_rst_count", count, 2);
    checkOutput("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_pq_rst", pq_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_init", pq_rst, 1);
    applyStimulus(1, 16'd50, 0, 1, 0);
    checkOutput("post_rst_run", pq_rst, 0);
    checkOutput("post_rst_enq_ready", enq_ready, 1);
    applyStimulus(0, 16'd0, 1, 1, 0);
    checkOutput("post_rst_count", count, 1);
    checkOutput("post_rst_deq_ready", deq_ready, 1);
    exp_q.push_back(mk(16'd50));
    applyStimulus(0, 16'd0, 0, 1, 0);
    #3;
    checkOutput("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
